// File: rtl/uart_tx_byte_if.sv
// Handshake and serial-line bundle between the packet send controller
// (master) and the UART byte transmitter (slave).
interface uart_tx_byte_if;
  logic       iniciar_envio;
  logic [7:0] dado_entrada;
  logic       uart_ocupado;
  logic       tx;
  logic       byte_enviado;

  modport master (
    output iniciar_envio,
    output dado_entrada,
    input  uart_ocupado,
    input  tx,
    input  byte_enviado
  );

  modport slave (
    input  iniciar_envio,
    input  dado_entrada,
    output uart_ocupado,
    output tx,
    output byte_enviado
  );
endinterface

// File: rtl/uart_tx_byte.sv
// UART byte transmitter: one byte per start pulse, 8 data bits LSB first,
// STOP_BITS stop bits, registered tx line (idle high).
// Optional parity bit after bit 7 when UART_TX_PARITY_EN is defined
// (PARITY_ODD selects odd parity).
module uart_tx_byte #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int unsigned STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD   = 0
`endif
) (
  input logic            clock,
  input logic            reset,
  uart_tx_byte_if.slave  bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT * STOP_BITS) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY
`endif
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] baud_q, baud_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shreg_q, shreg_n;
  logic          busy_q, busy_n;
  logic          tx_q, tx_n;
  logic          done_q, done_n;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (PARITY_ODD != 0) ? ~^shreg_q : ^shreg_q;
`endif

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shreg_q <= shreg_n;
      busy_q  <= busy_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic; tx is computed one edge ahead so each bit starts
  // on the edge that enters it (start bit falls on the accepting edge).
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q + CW'(1);
    bit_n   = bit_q;
    shreg_n = shreg_q;
    busy_n  = busy_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (bus.iniciar_envio) begin
          shreg_n = bus.dado_entrada;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baud_q == BIT_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg_q[0];
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_n = '0;
          bit_n  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_n    = parity_bit;
            state_n = S_PARITY;
`else
            tx_n    = 1'b1;
            state_n = S_STOP;
`endif
          end else begin
            tx_n = shreg_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == BIT_LAST) begin
          baud_n  = '0;
          tx_n    = 1'b1;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_n  = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        baud_n  = '0;
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  // Busy is visible combinationally in the cycle a start is presented.
  assign bus.uart_ocupado = busy_q | (bus.iniciar_envio & (state_q == S_IDLE));
  assign bus.tx           = tx_q;
  assign bus.byte_enviado = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Randomised scoreboard bench for uart_tx_byte (CLKS_PER_BIT = 10).
module tb_uart_tx_byte;
  localparam int unsigned CPB = 10;
  localparam int unsigned SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PODD  = 0;
  localparam int unsigned FRAME = (1 + 8 + 1 + SB) * CPB;
`else
  localparam int unsigned FRAME = (1 + 8 + SB) * CPB;
`endif

  typedef struct {
    logic [7:0]  b;
    int unsigned acc;
  } frame_t;

  logic        clock;
  logic        reset;
  int unsigned cyc;
  int unsigned checks;
  int unsigned failures;
  int unsigned model_free;
  frame_t      sb[$];

  uart_tx_byte_if bus();

  uart_tx_byte #(.CLK_HZ(1000), .BAUD(100), .STOP_BITS(SB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic ref_parity(input logic [7:0] b);
    int unsigned ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += b[i];
`ifdef UART_TX_PARITY_EN
    return ((ones % 2) == 1) ^ (PODD != 0);
`else
    return ones[0];
`endif
  endfunction

  // Line level k cycles after the accepting edge, from the frame layout.
  function automatic logic ref_line(input logic [7:0] b, input int unsigned k);
    int unsigned slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ref_parity(b);
`endif
    return 1'b1;
  endfunction

  // Monitor: compares line, busy and completion pulse against the queue head.
  always @(negedge clock) begin
    logic        exp_tx, exp_done, exp_busy;
    int unsigned k;
    if (!reset) begin
      exp_tx   = 1'b1;
      exp_done = 1'b0;
      exp_busy = bus.iniciar_envio;
      k        = 0;
      if (sb.size() > 0 && cyc >= sb[0].acc) begin
        k = cyc - sb[0].acc;
        if (k < FRAME) begin
          exp_tx   = ref_line(sb[0].b, k);
          exp_busy = 1'b1;
        end else if (k == FRAME) begin
          exp_done = 1'b1;
        end
      end
      check("tx", bus.tx, exp_tx);
      check("uart_ocupado", bus.uart_ocupado, exp_busy);
      check("byte_enviado", bus.byte_enviado, exp_done);
      if (sb.size() > 0 && cyc >= sb[0].acc) begin
        if (bus.byte_enviado) begin
          check("frame_length", k, FRAME);
          void'(sb.pop_front());
        end else if (k > FRAME) begin
          check("missing_done", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input logic [7:0] b, output int unsigned acc, output bit accepted);
    frame_t f;
    bus.iniciar_envio = 1'b1;
    bus.dado_entrada  = b;
    acc      = cyc + 1;
    accepted = (acc >= model_free);
    if (accepted) begin
      f.b = b;
      f.acc = acc;
      sb.push_back(f);
      model_free = acc + FRAME + 1;
    end
    #1 check("busy_comb", bus.uart_ocupado, 1);
    tick();
    bus.iniciar_envio = 1'b0;
    bus.dado_entrada  = 8'($urandom);
    #1;
    if (accepted) check("busy_reg", bus.uart_ocupado, 1);
  endtask

  task automatic wait_cycle(input int unsigned target);
    int unsigned n;
    n = 0;
    while (cyc < target && n < 5000) begin
      tick();
      n++;
    end
    if (cyc < target) check("wait_cycle_timeout", cyc, target);
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (sb.size() > 0 && n < 5000) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      check("wait_idle_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    int unsigned a, a2;
    bit ok;
    cyc = 0;
    checks = 0;
    failures = 0;
    model_free = 0;
    reset = 1'b1;
    bus.iniciar_envio = 1'b0;
    bus.dado_entrada  = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("reset_tx", bus.tx, 1);
    check("reset_busy", bus.uart_ocupado, 0);
    check("reset_done", bus.byte_enviado, 0);
    repeat (2) tick();

    // single byte
    start_req(8'hAC, a, ok);
    check("accept_single", ok, 1);
    wait_idle();

    // start while busy is ignored
    start_req(8'hAC, a, ok);
    wait_cycle(a + 40);
    start_req(8'h55, a2, ok);
    check("ignored_start", ok, 0);
    wait_idle();
    repeat (20) tick();

    // back-to-back: second start in the first idle cycle after completion
    start_req(8'h12, a, ok);
    wait_cycle(a + FRAME);
    start_req(8'h34, a2, ok);
    check("b2b_accept", ok, 1);
    check("b2b_spacing", a2 - a, FRAME + 1);
    wait_idle();

    // reset in the middle of a frame
    start_req(8'hC3, a, ok);
    wait_cycle(a + 55);
    #1 reset = 1'b1;
    sb.delete();
    model_free = 0;
    #1;
    check("midreset_tx", bus.tx, 1);
    check("midreset_busy", bus.uart_ocupado, 0);
    check("midreset_done", bus.byte_enviado, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    start_req(8'h5A, a, ok);
    check("post_reset_accept", ok, 1);
    wait_idle();

    // single set bit (odd population)
    start_req(8'h01, a, ok);
    wait_idle();

    // randomised traffic with stray starts while busy
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 25)) tick();
      start_req(8'($urandom), a, ok);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, FRAME - 5)) tick();
        start_req(8'($urandom), a2, ok);
      end
    end
    wait_idle();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Serial UART transmitter that sits directly downstream of the full-map packet send controller.
- Accepts one byte per start pulse and serialises it on the `tx` line as 8N1 (8 data bits LSB-first, no parity, STOP_BITS stop bits, 8N1 when STOP_BITS=1) at the configured baud rate.
- Reports busy status so the upstream controller can pace the event-code and map bytes.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer divide, 434 at defaults), clock cycles per serial bit; must be ≥ 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- iniciar_envio  input  1  start request; sampled high for one cycle to launch a frame.
- dado_entrada  input  8  byte to transmit; sampled in the same cycle iniciar_envio is accepted.
- uart_ocupado  output  1  transmitter busy.
- tx  output  1  serial line, idle high.
- byte_enviado  output  1  one-cycle pulse when a frame, including its stop bit(s), completes.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high; clock is `clock`.
  - On reset: tx=1, byte_enviado=0, internal busy register=0, state=S_IDLE, bit counter=0, baud counter=0, shift register=0.
  - Reset asserted mid-frame aborts the frame immediately: tx returns high asynchronously and no byte_enviado pulse is produced.
- States:
  - S_IDLE → S_START → S_DATA → S_STOP → S_IDLE.
  - When UART_TX_PARITY_EN is defined, S_PARITY is inserted between S_DATA and S_STOP.
- S_IDLE:
  - tx=1.
  - On iniciar_envio=1: latch dado_entrada into the shift register, set the busy register, clear the baud counter, go to S_START.
- S_START:
  - tx=0 for CLKS_PER_BIT cycles; tx falls on the clock edge that accepts the start.
- S_DATA:
  - 8 bits, each held CLKS_PER_BIT cycles, LSB first.
  - A 3-bit index increments after each bit.
  - After bit 7 completes, go to S_STOP (or S_PARITY).
- S_STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final cycle: clear the busy register, pulse byte_enviado for exactly one cycle, return to S_IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is cleared on every state change.
  - Width is $clog2(CLKS_PER_BIT*STOP_BITS)+1 so it does not overflow.
- Busy semantics:
  - uart_ocupado = busy register OR (iniciar_envio AND state==S_IDLE).
  - This combinational term makes busy visible in the same cycle the start is presented, so an upstream FSM that samples busy one cycle after asserting start never sees a false idle.
- Frame length:
  - From the accepting edge to byte_enviado is exactly (1+8+STOP_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
  - uart_ocupado falls on the same edge that byte_enviado rises.
- Start while busy: iniciar_envio while not in S_IDLE is ignored. The frame in flight and its latched byte are unaffected, and nothing is queued.
- Back-to-back frames:
  - A start presented in the first S_IDLE cycle after byte_enviado is accepted.
  - The minimum idle gap on tx between frames is therefore one clock cycle.
- dado_entrada changes after acceptance have no effect on the frame in flight.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Parameter PARITY_ODD (default 0) is added.
  - State S_PARITY transmits one parity bit for CLKS_PER_BIT cycles after bit 7.
  - The parity bit is ^data for even parity, or ~^data when PARITY_ODD=1, computed from the latched byte.
  - Frame length grows by CLKS_PER_BIT.
- Undefined:
  - No parity state, logic, or parameter exists.
  - Frame is 8N1 (with STOP_BITS stop bits).

Test Plan (CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10):
- Single byte:
  - Stimulus: after reset, 1-cycle start with dado_entrada=8'hAC.
  - Response: tx = 0 (10 cycles), then 0,0,1,1,0,1,0,1 (10 cycles each), then 1.
  - byte_enviado pulses once at cycle 100; uart_ocupado is high from the start cycle through cycle 99.
- Busy visibility:
  - Stimulus: start asserted.
  - Response: uart_ocupado=1 combinationally in the same cycle.
  - Response: on the next cycle uart_ocupado is still 1 from the busy register.
- Ignored start:
  - Stimulus: second start with 8'h55 at cycle 40 of an 8'hAC frame.
  - Response: 8'hAC waveform unchanged, exactly one byte_enviado pulse, tx stays high afterwards.
- Back-to-back:
  - Stimulus: 8'h12, then 8'h34 started in the first idle cycle after byte_enviado.
  - Response: two correct frames, 1-cycle high gap, two byte_enviado pulses 101 cycles apart.
- Reset mid-frame:
  - Stimulus: assert reset at cycle 55 of a frame.
  - Response: tx=1 and uart_ocupado=0 immediately, no byte_enviado, and the next start transmits normally.
- Parity:
  - Stimulus: UART_TX_PARITY_EN defined, PARITY_ODD=0, byte 8'hAC.
  - Response: parity bit 0; byte 8'h01 gives parity bit 1.
  - Response: byte_enviado at cycle 110.
